// File: rtl/controller_multicycle_rv32i_pkg.sv
// rtl/controller_multicycle_rv32i_pkg.sv - shared types and select codes for the multi-cycle RV32I controller
// Contents: AluOp, CtrlState, InstClass enums; register-write, PC-next, operand and
// memory-address select codes; RV32I opcodes; funct3 -> AluOp helper.
package controller_multicycle_rv32i_pkg;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_SLL  = 4'd2,
    ALU_SLT  = 4'd3,
    ALU_SLTU = 4'd4,
    ALU_XOR  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_OR   = 4'd8,
    ALU_AND  = 4'd9
  } AluOp;

  typedef enum logic [2:0] {
    S_FETCH     = 3'd0,
    S_DECODE    = 3'd1,
    S_EXECUTE   = 3'd2,
    S_MEMORY    = 3'd3,
    S_WRITEBACK = 3'd4,
    S_HALT      = 3'd5
  } CtrlState;

  typedef enum logic [3:0] {
    IC_ALU_R   = 4'd0,
    IC_ALU_I   = 4'd1,
    IC_LUI     = 4'd2,
    IC_AUIPC   = 4'd3,
    IC_LOAD    = 4'd4,
    IC_STORE   = 4'd5,
    IC_BRANCH  = 4'd6,
    IC_JAL     = 4'd7,
    IC_JALR    = 4'd8,
    IC_ILLEGAL = 4'd9
  } InstClass;

  localparam logic [1:0] WR_ALU = 2'b00;
  localparam logic [1:0] WR_MEM = 2'b01;
  localparam logic [1:0] WR_PC4 = 2'b10;

  localparam logic [1:0] PC_PLUS4      = 2'b00;
  localparam logic [1:0] PC_OFFSET     = 2'b01;
  localparam logic [1:0] PC_RS1_OFFSET = 2'b10;

  localparam logic [1:0] OPA_RS1  = 2'b00;
  localparam logic [1:0] OPA_PC   = 2'b01;
  localparam logic [1:0] OPA_ZERO = 2'b10;

  localparam logic OPB_RS2 = 1'b0;
  localparam logic OPB_IMM = 1'b1;

  localparam logic MEM_ADDR_PC  = 1'b0;
  localparam logic MEM_ADDR_ALU = 1'b1;

  localparam logic [6:0] OP_ALU_R  = 7'b0110011;
  localparam logic [6:0] OP_ALU_I  = 7'b0010011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  // alt selects SUB over ADD and SRA over SRL (funct7 bit 5).
  function automatic AluOp alu_from_funct3(input logic [2:0] funct3, input logic alt);
    case (funct3)
      3'b000:  return alt ? ALU_SUB : ALU_ADD;
      3'b001:  return ALU_SLL;
      3'b010:  return ALU_SLT;
      3'b011:  return ALU_SLTU;
      3'b100:  return ALU_XOR;
      3'b101:  return alt ? ALU_SRA : ALU_SRL;
      3'b110:  return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

endpackage

// File: rtl/decoder_rv32i.sv
// rtl/decoder_rv32i.sv - combinational RV32I instruction classifier and ALU/operand decode
// Ports: i_Inst (instruction register) -> inst_class, alu_op, operand_a_sel, operand_b_sel.
module decoder_rv32i
  import controller_multicycle_rv32i_pkg::*;
(
  input  logic [31:0] i_Inst,
  output InstClass    inst_class,
  output AluOp        alu_op,
  output logic [1:0]  operand_a_sel,
  output logic        operand_b_sel
);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       unused_fields;

  assign opcode = i_Inst[6:0];
  assign funct3 = i_Inst[14:12];
  assign funct7 = i_Inst[31:25];
  // Register indices and immediates are consumed by the datapath, not here.
  assign unused_fields = ^{i_Inst[24:15], i_Inst[11:7]};

  always_comb begin
    inst_class    = IC_ILLEGAL;
    alu_op        = ALU_ADD;
    operand_a_sel = OPA_RS1;
    operand_b_sel = OPB_RS2;
    case (opcode)
      OP_ALU_R: begin
        // Only ADD/SUB and SRL/SRA have an alternate funct7 encoding.
        if (funct7 == 7'b0000000 ||
            (funct7 == 7'b0100000 && (funct3 == 3'b000 || funct3 == 3'b101))) begin
          inst_class = IC_ALU_R;
          alu_op     = alu_from_funct3(funct3, funct7[5]);
        end
      end
      OP_ALU_I: begin
        operand_b_sel = OPB_IMM;
        // Upper immediate bits are a real immediate except for shifts.
        if ((funct3 == 3'b001 && funct7 != 7'b0000000) ||
            (funct3 == 3'b101 && funct7 != 7'b0000000 && funct7 != 7'b0100000)) begin
          inst_class = IC_ILLEGAL;
        end else begin
          inst_class = IC_ALU_I;
          alu_op     = alu_from_funct3(funct3, funct3 == 3'b101 && funct7[5]);
        end
      end
      OP_LUI: begin
        inst_class    = IC_LUI;
        operand_a_sel = OPA_ZERO;
        operand_b_sel = OPB_IMM;
      end
      OP_AUIPC: begin
        inst_class    = IC_AUIPC;
        operand_a_sel = OPA_PC;
        operand_b_sel = OPB_IMM;
      end
      OP_LOAD: begin
        operand_b_sel = OPB_IMM;
        if (funct3 != 3'b011 && funct3 != 3'b110 && funct3 != 3'b111) inst_class = IC_LOAD;
      end
      OP_STORE: begin
        operand_b_sel = OPB_IMM;
        if (funct3 == 3'b000 || funct3 == 3'b001 || funct3 == 3'b010) inst_class = IC_STORE;
      end
      OP_BRANCH: begin
        if (funct3 != 3'b010 && funct3 != 3'b011) inst_class = IC_BRANCH;
      end
      OP_JAL: begin
        inst_class    = IC_JAL;
        operand_a_sel = OPA_PC;
        operand_b_sel = OPB_IMM;
      end
      OP_JALR: begin
        operand_b_sel = OPB_IMM;
        if (funct3 == 3'b000) inst_class = IC_JALR;
      end
      default: inst_class = IC_ILLEGAL;
    endcase
  end

endmodule

// File: rtl/controller_multicycle_rv32i.sv
// rtl/controller_multicycle_rv32i.sv - multi-cycle RV32I sequencer over a shared memory port
// Ports: i_Clock, i_Reset (sync, active-low), i_Inst, i_IsEQ, i_IsLT, i_MemAck in;
// memory request/write/address select, IR/PC/register-file enables, PC-next,
// ALU and operand selects, write-data select and o_Halted out.
// Build option: ILLEGAL_INST_TRAP_EN makes illegal instructions halt the core.
module controller_multicycle_rv32i
  import controller_multicycle_rv32i_pkg::*;
(
  input  logic        i_Clock,
  input  logic        i_Reset,
  input  logic [31:0] i_Inst,
  input  logic        i_IsEQ,
  input  logic        i_IsLT,
  input  logic        i_MemAck,
  output logic        o_MemReq,
  output logic        o_MemWrEnable,
  output logic        o_MemAddrSel,
  output logic        o_InstWrEnable,
  output logic        o_PCWrEnable,
  output logic [1:0]  o_PCNextSel,
  output AluOp        o_AluControl,
  output logic [1:0]  o_OperandASel,
  output logic        o_OperandBSel,
  output logic        o_RegWrEnable,
  output logic [1:0]  o_RegWrDataSel,
  output logic        o_Halted
);

  CtrlState   state;
  InstClass   inst_class;
  AluOp       dec_alu_op;
  logic [1:0] dec_operand_a_sel;
  logic       dec_operand_b_sel;
  logic [2:0] funct3;
  logic       branch_taken;

  decoder_rv32i u_decoder (
    .i_Inst        (i_Inst),
    .inst_class    (inst_class),
    .alu_op        (dec_alu_op),
    .operand_a_sel (dec_operand_a_sel),
    .operand_b_sel (dec_operand_b_sel)
  );

  // funct3[2] picks LT vs EQ comparison, funct3[0] inverts it (BNE/BGE/BGEU).
  assign funct3       = i_Inst[14:12];
  assign branch_taken = (funct3[2] ? i_IsLT : i_IsEQ) ^ funct3[0];

  always_ff @(posedge i_Clock) begin
    if (!i_Reset) begin
      state <= S_FETCH;
    end else begin
      case (state)
        S_FETCH:  if (i_MemAck) state <= S_DECODE;
        S_DECODE: state <= S_EXECUTE;
        S_EXECUTE: begin
          case (inst_class)
            IC_LOAD, IC_STORE: state <= S_MEMORY;
            IC_ALU_R, IC_ALU_I, IC_LUI, IC_AUIPC: state <= S_WRITEBACK;
            IC_ILLEGAL: begin
`ifdef ILLEGAL_INST_TRAP_EN
              state <= S_HALT;
`else
              state <= S_FETCH;
`endif
            end
            default: state <= S_FETCH;
          endcase
        end
        S_MEMORY: begin
          if (i_MemAck) state <= (inst_class == IC_STORE) ? S_FETCH : S_WRITEBACK;
        end
        S_WRITEBACK: state <= S_FETCH;
        S_HALT: begin
`ifdef ILLEGAL_INST_TRAP_EN
          state <= S_HALT;
`else
          state <= S_FETCH;
`endif
        end
        default: state <= S_FETCH;
      endcase
    end
  end

  // Outputs are forced to zero while reset is held, regardless of state.
  always_comb begin
    o_MemReq       = 1'b0;
    o_MemWrEnable  = 1'b0;
    o_MemAddrSel   = MEM_ADDR_PC;
    o_InstWrEnable = 1'b0;
    o_PCWrEnable   = 1'b0;
    o_PCNextSel    = PC_PLUS4;
    o_AluControl   = ALU_ADD;
    o_OperandASel  = OPA_RS1;
    o_OperandBSel  = OPB_RS2;
    o_RegWrEnable  = 1'b0;
    o_RegWrDataSel = WR_ALU;
    o_Halted       = 1'b0;
    if (i_Reset) begin
      // ALU controls stay valid from EXECUTE through the writeback that consumes the result.
      if (state == S_EXECUTE || state == S_MEMORY || state == S_WRITEBACK) begin
        o_AluControl  = dec_alu_op;
        o_OperandASel = dec_operand_a_sel;
        o_OperandBSel = dec_operand_b_sel;
      end
      case (state)
        S_FETCH: begin
          o_MemReq       = 1'b1;
          o_MemAddrSel   = MEM_ADDR_PC;
          o_InstWrEnable = i_MemAck;
        end
        S_EXECUTE: begin
          case (inst_class)
            IC_BRANCH: begin
              o_PCWrEnable = 1'b1;
              o_PCNextSel  = branch_taken ? PC_OFFSET : PC_PLUS4;
            end
            IC_JAL: begin
              o_RegWrEnable  = 1'b1;
              o_RegWrDataSel = WR_PC4;
              o_PCWrEnable   = 1'b1;
              o_PCNextSel    = PC_OFFSET;
            end
            IC_JALR: begin
              o_RegWrEnable  = 1'b1;
              o_RegWrDataSel = WR_PC4;
              o_PCWrEnable   = 1'b1;
              o_PCNextSel    = PC_RS1_OFFSET;
            end
            IC_ILLEGAL: begin
`ifndef ILLEGAL_INST_TRAP_EN
              o_PCWrEnable = 1'b1;
`endif
            end
            default: o_PCWrEnable = 1'b0;
          endcase
        end
        S_MEMORY: begin
          o_MemReq      = 1'b1;
          o_MemAddrSel  = MEM_ADDR_ALU;
          o_MemWrEnable = (inst_class == IC_STORE);
          o_PCWrEnable  = i_MemAck && (inst_class == IC_STORE);
        end
        S_WRITEBACK: begin
          o_RegWrEnable  = 1'b1;
          o_RegWrDataSel = (inst_class == IC_LOAD) ? WR_MEM : WR_ALU;
          o_PCWrEnable   = 1'b1;
        end
        S_HALT: begin
`ifdef ILLEGAL_INST_TRAP_EN
          o_Halted = 1'b1;
`endif
        end
        default: o_Halted = 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_controller_multicycle_rv32i.sv
// tb/tb_controller_multicycle_rv32i.sv - directed per-cycle check of the multi-cycle controller outputs
module tb_controller_multicycle_rv32i;
  import controller_multicycle_rv32i_pkg::*;

  logic        i_Clock;
  logic        i_Reset;
  logic [31:0] i_Inst;
  logic        i_IsEQ;
  logic        i_IsLT;
  logic        i_MemAck;
  logic        o_MemReq;
  logic        o_MemWrEnable;
  logic        o_MemAddrSel;
  logic        o_InstWrEnable;
  logic        o_PCWrEnable;
  logic [1:0]  o_PCNextSel;
  AluOp        o_AluControl;
  logic [1:0]  o_OperandASel;
  logic        o_OperandBSel;
  logic        o_RegWrEnable;
  logic [1:0]  o_RegWrDataSel;
  logic        o_Halted;

  int n_pass;
  int n_total;

  controller_multicycle_rv32i dut (
    .i_Clock        (i_Clock),
    .i_Reset        (i_Reset),
    .i_Inst         (i_Inst),
    .i_IsEQ         (i_IsEQ),
    .i_IsLT         (i_IsLT),
    .i_MemAck       (i_MemAck),
    .o_MemReq       (o_MemReq),
    .o_MemWrEnable  (o_MemWrEnable),
    .o_MemAddrSel   (o_MemAddrSel),
    .o_InstWrEnable (o_InstWrEnable),
    .o_PCWrEnable   (o_PCWrEnable),
    .o_PCNextSel    (o_PCNextSel),
    .o_AluControl   (o_AluControl),
    .o_OperandASel  (o_OperandASel),
    .o_OperandBSel  (o_OperandBSel),
    .o_RegWrEnable  (o_RegWrEnable),
    .o_RegWrDataSel (o_RegWrDataSel),
    .o_Halted       (o_Halted)
  );

  initial i_Clock = 1'b0;
  always #5 i_Clock = ~i_Clock;

  // {mreq, mwr, asel, iwr, pcwr, pcsel[1:0], alu[3:0], opa[1:0], opb, rwr, wsel[1:0], halt}
  logic [17:0] obs;
  assign obs = {o_MemReq, o_MemWrEnable, o_MemAddrSel, o_InstWrEnable, o_PCWrEnable,
                o_PCNextSel, o_AluControl, o_OperandASel, o_OperandBSel,
                o_RegWrEnable, o_RegWrDataSel, o_Halted};

  function automatic logic [17:0] ctl(input logic mreq, input logic mwr, input logic asel,
                                      input logic iwr, input logic pcwr, input logic [1:0] pcsel,
                                      input logic [3:0] alu, input logic [1:0] opa, input logic opb,
                                      input logic rwr, input logic [1:0] wsel, input logic halt);
    return {mreq, mwr, asel, iwr, pcwr, pcsel, alu, opa, opb, rwr, wsel, halt};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: observed %h expected %h", tag, got, exp);
  endtask

  // One clock: drive inputs after the falling edge, sample combinational outputs 1ns later.
  task automatic step(input string tag, input logic rst, input logic [31:0] inst,
                      input logic ack, input logic eq, input logic lt, input logic [17:0] exp);
    @(negedge i_Clock);
    i_Reset  = rst;
    i_Inst   = inst;
    i_MemAck = ack;
    i_IsEQ   = eq;
    i_IsLT   = lt;
    #1;
    check(tag, {14'd0, obs}, {14'd0, exp});
  endtask

  localparam logic [31:0] I_ADDI = 32'h00500093;  // addi x1,x0,5
  localparam logic [31:0] I_LW   = 32'h0000A103;  // lw   x2,0(x1)
  localparam logic [31:0] I_SW   = 32'h0020A223;  // sw   x2,4(x1)
  localparam logic [31:0] I_BEQ  = 32'h00208463;  // beq  x1,x2,8
  localparam logic [31:0] I_BNE  = 32'h00209463;  // bne  x1,x2,8
  localparam logic [31:0] I_BLT  = 32'h0020C463;  // blt  x1,x2,8
  localparam logic [31:0] I_JALR = 32'h000100E7;  // jalr x1,0(x2)
  localparam logic [31:0] I_JAL  = 32'h010000EF;  // jal  x1,16
  localparam logic [31:0] I_SUB  = 32'h402081B3;  // sub  x3,x1,x2
  localparam logic [31:0] I_LUI  = 32'h123452B7;  // lui  x5,0x12345
  localparam logic [31:0] I_ILL  = 32'h0000007F;

  logic [17:0] v_fetch_ack;
  logic [17:0] v_fetch_wait;
  logic [17:0] v_zero;
  logic [17:0] v_mem_exec;

  initial begin
    n_pass   = 0;
    n_total  = 0;
    i_Reset  = 1'b0;
    i_Inst   = 32'd0;
    i_IsEQ   = 1'b0;
    i_IsLT   = 1'b0;
    i_MemAck = 1'b0;
    v_fetch_ack  = ctl(1,0,0,1,0,2'b00,ALU_ADD,2'b00,0,0,2'b00,0);
    v_fetch_wait = ctl(1,0,0,0,0,2'b00,ALU_ADD,2'b00,0,0,2'b00,0);
    v_zero       = 18'd0;
    v_mem_exec   = ctl(0,0,0,0,0,2'b00,ALU_ADD,2'b00,1,0,2'b00,0);

    // Reset: all outputs zero even with an ack present.
    step("rst0", 0, I_ADDI, 1, 0, 0, v_zero);
    step("rst1", 0, I_ADDI, 1, 1, 1, v_zero);

    // ADDI, zero-wait fetch; ack during DECODE is ignored.
    step("addi_f", 1, I_ADDI, 1, 0, 0, v_fetch_ack);
    step("addi_d", 1, I_ADDI, 1, 0, 0, v_zero);
    step("addi_e", 1, I_ADDI, 0, 0, 0, ctl(0,0,0,0,0,2'b00,ALU_ADD,2'b00,1,0,2'b00,0));
    step("addi_w", 1, I_ADDI, 0, 0, 0, ctl(0,0,0,0,1,2'b00,ALU_ADD,2'b00,1,1,2'b00,0));

    // LW: one fetch wait, then MEMORY held 4 cycles by a 3-cycle late ack.
    step("lw_fw", 1, I_LW, 0, 0, 0, v_fetch_wait);
    step("lw_f",  1, I_LW, 1, 0, 0, v_fetch_ack);
    step("lw_d",  1, I_LW, 0, 0, 0, v_zero);
    step("lw_e",  1, I_LW, 0, 0, 0, v_mem_exec);
    for (int i = 0; i < 3; i++)
      step("lw_mwait", 1, I_LW, 0, 0, 0, ctl(1,0,1,0,0,2'b00,ALU_ADD,2'b00,1,0,2'b00,0));
    step("lw_mack", 1, I_LW, 1, 0, 0, ctl(1,0,1,0,0,2'b00,ALU_ADD,2'b00,1,0,2'b00,0));
    step("lw_w",    1, I_LW, 0, 0, 0, ctl(0,0,0,0,1,2'b00,ALU_ADD,2'b00,1,1,2'b01,0));

    // Branches: 3 cycles, PC write in EXECUTE only.
    step("beq1_f", 1, I_BEQ, 1, 0, 0, v_fetch_ack);
    step("beq1_d", 1, I_BEQ, 0, 0, 0, v_zero);
    step("beq1_e", 1, I_BEQ, 0, 1, 0, ctl(0,0,0,0,1,2'b01,ALU_ADD,2'b00,0,0,2'b00,0));
    step("beq0_f", 1, I_BEQ, 1, 0, 0, v_fetch_ack);
    step("beq0_d", 1, I_BEQ, 0, 0, 0, v_zero);
    step("beq0_e", 1, I_BEQ, 0, 0, 1, ctl(0,0,0,0,1,2'b00,ALU_ADD,2'b00,0,0,2'b00,0));
    step("bne_f",  1, I_BNE, 1, 0, 0, v_fetch_ack);
    step("bne_d",  1, I_BNE, 0, 0, 0, v_zero);
    step("bne_e",  1, I_BNE, 0, 1, 0, ctl(0,0,0,0,1,2'b00,ALU_ADD,2'b00,0,0,2'b00,0));
    step("blt_f",  1, I_BLT, 1, 0, 0, v_fetch_ack);
    step("blt_d",  1, I_BLT, 0, 0, 0, v_zero);
    step("blt_e",  1, I_BLT, 0, 0, 1, ctl(0,0,0,0,1,2'b01,ALU_ADD,2'b00,0,0,2'b00,0));

    // Jumps: link and PC write in EXECUTE, then FETCH.
    step("jalr_f", 1, I_JALR, 1, 0, 0, v_fetch_ack);
    step("jalr_d", 1, I_JALR, 0, 0, 0, v_zero);
    step("jalr_e", 1, I_JALR, 0, 0, 0, ctl(0,0,0,0,1,2'b10,ALU_ADD,2'b00,1,1,2'b10,0));
    step("jal_f",  1, I_JAL,  1, 0, 0, v_fetch_ack);
    step("jal_d",  1, I_JAL,  0, 0, 0, v_zero);
    step("jal_e",  1, I_JAL,  0, 0, 0, ctl(0,0,0,0,1,2'b01,ALU_ADD,2'b01,1,1,2'b10,0));

    // SUB and LUI operand mapping.
    step("sub_f", 1, I_SUB, 1, 0, 0, v_fetch_ack);
    step("sub_d", 1, I_SUB, 0, 0, 0, v_zero);
    step("sub_e", 1, I_SUB, 0, 0, 0, ctl(0,0,0,0,0,2'b00,ALU_SUB,2'b00,0,0,2'b00,0));
    step("sub_w", 1, I_SUB, 0, 0, 0, ctl(0,0,0,0,1,2'b00,ALU_SUB,2'b00,0,1,2'b00,0));
    step("lui_f", 1, I_LUI, 1, 0, 0, v_fetch_ack);
    step("lui_d", 1, I_LUI, 0, 0, 0, v_zero);
    step("lui_e", 1, I_LUI, 0, 0, 0, ctl(0,0,0,0,0,2'b00,ALU_ADD,2'b10,1,0,2'b00,0));
    step("lui_w", 1, I_LUI, 0, 0, 0, ctl(0,0,0,0,1,2'b00,ALU_ADD,2'b10,1,1,2'b00,0));

    // SW zero wait: PC write on the MEMORY ack cycle.
    step("sw_f", 1, I_SW, 1, 0, 0, v_fetch_ack);
    step("sw_d", 1, I_SW, 0, 0, 0, v_zero);
    step("sw_e", 1, I_SW, 0, 0, 0, v_mem_exec);
    step("sw_m", 1, I_SW, 1, 0, 0, ctl(1,1,1,0,1,2'b00,ALU_ADD,2'b00,1,0,2'b00,0));

    // SW interrupted by reset while waiting in MEMORY.
    step("swr_f",  1, I_SW, 1, 0, 0, v_fetch_ack);
    step("swr_d",  1, I_SW, 0, 0, 0, v_zero);
    step("swr_e",  1, I_SW, 0, 0, 0, v_mem_exec);
    step("swr_mw", 1, I_SW, 0, 0, 0, ctl(1,1,1,0,0,2'b00,ALU_ADD,2'b00,1,0,2'b00,0));
    step("swr_rst", 0, I_SW, 0, 0, 0, v_zero);
    step("swr_f2", 1, I_SW, 0, 0, 0, v_fetch_wait);
    step("swr_f3", 1, I_SW, 1, 0, 0, v_fetch_ack);
    step("swr_d2", 1, I_SW, 0, 0, 0, v_zero);
    step("swr_e2", 1, I_SW, 0, 0, 0, v_mem_exec);
    step("swr_m2", 1, I_SW, 1, 0, 0, ctl(1,1,1,0,1,2'b00,ALU_ADD,2'b00,1,0,2'b00,0));

    // Illegal opcode 0x7F.
    step("ill_f", 1, I_ILL, 1, 0, 0, v_fetch_ack);
    step("ill_d", 1, I_ILL, 0, 0, 0, v_zero);
`ifdef ILLEGAL_INST_TRAP_EN
    step("ill_e", 1, I_ILL, 0, 0, 0, v_zero);
    for (int i = 0; i < 3; i++)
      step("ill_halt", 1, I_ILL, 1, 0, 0, ctl(0,0,0,0,0,2'b00,ALU_ADD,2'b00,0,0,2'b00,1));
    step("ill_rst", 0, I_ILL, 1, 0, 0, v_zero);
    step("ill_f2",  1, I_ILL, 0, 0, 0, v_fetch_wait);
`else
    step("ill_e",  1, I_ILL, 0, 0, 0, ctl(0,0,0,0,1,2'b00,ALU_ADD,2'b00,0,0,2'b00,0));
    step("ill_f2", 1, I_ILL, 0, 0, 0, v_fetch_wait);
    step("ill_f3", 1, I_ILL, 1, 0, 0, v_fetch_ack);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/controller_multicycle_rv32i.md
# controller_multicycle_rv32i

Multi-cycle sequencer for the RV32I datapath. It steps each instruction through fetch, decode, execute, memory and writeback over a single shared memory port. It drives the same select and enable signals as the single-cycle controller, with one difference: each enable is asserted only in the state that owns it. Sits between the instruction register / shared memory port and the PC, register file, ALU and operand muxes.

## Interface
- No parameters.
- i_Clock  in  1  clock; all state updates on rising edge.
- i_Reset  in  1  synchronous, active-low reset.
- i_Inst  in  32  content of the instruction register (loaded by o_InstWrEnable).
- i_IsEQ  in  1  comparator A == B.
- i_IsLT  in  1  comparator A < B (signed/unsigned chosen by datapath from funct3).
- i_MemAck  in  1  memory completed the current request this cycle.
- o_MemReq  out  1  memory access request.
- o_MemWrEnable  out  1  request is a write (valid only with o_MemReq).
- o_MemAddrSel  out  1  0 = PC, 1 = ALU result.
- o_InstWrEnable  out  1  load instruction register from memory read data.
- o_PCWrEnable  out  1  update PC.
- o_PCNextSel  out  2  00 = PC+4, 01 = PC+offset, 10 = RS1+offset.
- o_AluControl  out  AluOp  ALU operation.
- o_OperandASel  out  2  00 = RS1, 01 = PC, 10 = zero.
- o_OperandBSel  out  1  0 = RS2, 1 = immediate.
- o_RegWrEnable  out  1  register file write.
- o_RegWrDataSel  out  2  00 = ALU, 01 = MEM, 10 = PC+4.
- o_Halted  out  1  illegal-instruction trap taken (see Configuration).

## Operation
- States: FETCH, DECODE, EXECUTE, MEMORY, WRITEBACK, HALT.
- FETCH:
  - o_MemReq=1, o_MemAddrSel=0.
  - Hold until i_MemAck.
  - On ack: o_InstWrEnable=1 for that cycle, then go to DECODE.
- DECODE:
  - One cycle. Classify i_Inst as ALU-R, ALU-I, LUI, AUIPC, LOAD, STORE, BRANCH, JAL, JALR or ILLEGAL.
  - All enables stay 0.
- EXECUTE:
  - ALU-R/ALU-I/LUI/AUIPC: drive ALU controls, then go to WRITEBACK.
  - LOAD/STORE: A=RS1, B=imm, ADD, then go to MEMORY.
  - BRANCH: o_PCWrEnable=1. o_PCNextSel=01 if the condition is met, else 00. Then go to FETCH.
    - BEQ taken if i_IsEQ; BNE if !i_IsEQ.
    - BLT/BLTU taken if i_IsLT; BGE/BGEU if !i_IsLT.
  - JAL/JALR: o_RegWrEnable=1, o_RegWrDataSel=10, o_PCWrEnable=1, o_PCNextSel=01/10. Then go to FETCH.
  - ILLEGAL: PC+4, then go to FETCH (or HALT, see Configuration).
- MEMORY:
  - o_MemReq=1, o_MemAddrSel=1, o_MemWrEnable=1 for STORE; hold ALU controls.
  - On ack, STORE: o_PCWrEnable=1 with 00, then go to FETCH.
  - On ack, LOAD: go to WRITEBACK.
- WRITEBACK:
  - o_RegWrEnable=1; o_RegWrDataSel=01 for LOAD, else 00.
  - o_PCWrEnable=1 with 00. Then go to FETCH.
- Operand mapping:
  - LUI: A=zero, B=imm, ADD.
  - AUIPC: A=PC, B=imm, ADD.
  - SUB/SLT/SLTU/XOR/OR/AND and their I-forms map to the matching AluOp.
  - XORI maps to XOR; ORI has B=imm.
- Handshake:
  - o_MemReq and the address select must stay stable until i_MemAck.
  - i_MemAck outside FETCH/MEMORY is ignored.
  - Ack in the same cycle as the request is legal (zero wait).

## Timing
- Reset:
  - i_Reset=0 at any edge gives state=FETCH next cycle.
  - Every output is 0 while in reset, and o_Halted=0.
  - An outstanding request is dropped; a late i_MemAck after reset counts as a FETCH ack only if it arrives while FETCH is requesting.
- Cycles per instruction with zero-wait memory:
  - BRANCH/JAL/JALR: 3.
  - ALU/LUI/AUIPC: 4.
  - STORE: 4.
  - LOAD: 5.
- Each wait cycle of memory adds one cycle.
- PC and register writes occur only at the last cycle of an instruction. At most one o_PCWrEnable pulse per instruction.
- All outputs are decoded combinationally from registered state plus i_Inst/i_IsEQ/i_IsLT/i_MemAck. Only the state register is sequential.

## Configuration
- ILLEGAL_INST_TRAP_EN defined:
  - ILLEGAL goes EXECUTE→HALT with no PC write.
  - HALT holds o_Halted=1 and all enables 0 until reset.
- Undefined:
  - ILLEGAL executes as NOP (PC+4, then FETCH).
  - HALT is unreachable; o_Halted is tied 0.

## Structure
- Package types:
  - existing AluOp;
  - new CtrlState enum;
  - new InstClass enum;
  - localparams for wr*/pc* select codes and operand-A codes.
- Sub-module decoder_rv32i: combinational i_Inst → {InstClass, AluOp, operand selects}. The FSM owns only sequencing and enables.

## Test plan
- ADDI x1,x0,5 with zero-wait memory → enables sequence FETCH,DECODE,EXECUTE,WRITEBACK. RegWrEnable=1, DataSel=00, OperandBSel=1, PCWrEnable=1 with sel 00, all in cycle 4.
- LW with i_MemAck delayed 3 cycles in MEMORY → o_MemReq=1, MemAddrSel=1 held stable for 4 cycles; WRITEBACK asserts DataSel=01; total 8 cycles.
- BEQ with i_IsEQ=1, then with i_IsEQ=0 → PCNextSel=01, then 00. RegWrEnable=0; 3 cycles each.
- JALR → in EXECUTE: RegWrEnable=1, DataSel=10, PCNextSel=10; next state FETCH.
- i_Reset=0 during a waiting MEMORY store → next cycle all outputs 0; after release, FETCH request with MemAddrSel=0 and no memory write.
- Opcode 0x7F with ILLEGAL_INST_TRAP_EN → o_Halted=1 from cycle 4; i_MemAck pulses ignored. Without the macro → PCWrEnable pulse with sel 00, then FETCH.
